// File: rtl/median_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// median_seq_ctrl_pkg : shared state encodings and default frame geometry
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package median_seq_ctrl_pkg;

  localparam int N_DEFAULT = 7;
  localparam int W_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_SORT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // $clog2 clamped to at least one bit so degenerate counters stay legal
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

`default_nettype wire

// File: rtl/median_seq_ctrl_cas_unit.sv
// ---------------------------------------------------------------------------
// cas_unit : combinational unsigned compare-and-swap (lo = min, hi = max)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cas_unit
  import median_seq_ctrl_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  always_comb begin
    if (b < a) begin
      lo = b;
      hi = a;
    end else begin
      lo = a;
      hi = b;
    end
  end

endmodule

`default_nettype wire

// File: rtl/median_seq_ctrl.sv
// ---------------------------------------------------------------------------
// median_seq_ctrl : frame loader + odd-even transposition sort on one CAS unit
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module median_seq_ctrl
  import median_seq_ctrl_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] median,
  output logic         busy
);

  localparam int CW   = $clog2(N);
  localparam int PW   = $clog2(N);
  localparam int IW   = $clog2(N);
  localparam int HALF = (N - 1) / 2;
  localparam int KW   = clog2_min1(HALF);
  localparam int MID  = HALF;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [PW-1:0]  pass;
  logic [KW-1:0]  k;
  logic [W-1:0]   samples [N];

  logic [IW-1:0]  idx_lo;
  logic [IW-1:0]  idx_hi;
  logic [W-1:0]   cas_a;
  logic [W-1:0]   cas_b;
  logic [W-1:0]   cas_lo;
  logic [W-1:0]   cas_hi;
  logic [W-1:0]   mid_next;

  // Pair index i = 2*k + pass[0]: even passes start at 0, odd passes at 1
  assign idx_lo = IW'({k, pass[0]});
  assign idx_hi = idx_lo + 1'b1;
  assign cas_a  = samples[idx_lo];
  assign cas_b  = samples[idx_hi];

  cas_unit #(.W(W)) u_cas (
    .a  (cas_a),
    .b  (cas_b),
    .lo (cas_lo),
    .hi (cas_hi)
  );

  // Middle element as it will look after this cycle's write-back
  always_comb begin
    mid_next = samples[MID];
    if (int'(idx_lo) == MID) begin
      mid_next = cas_lo;
    end else if (int'(idx_hi) == MID) begin
      mid_next = cas_hi;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_LOAD;
      cnt       <= '0;
      pass      <= '0;
      k         <= '0;
      median    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      for (int j = 0; j < N; j++) begin
        samples[j] <= '0;
      end
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_valid) begin
            samples[cnt] <= in_data;
            if (cnt == CW'(N - 1)) begin
              cnt      <= '0;
              pass     <= '0;
              k        <= '0;
              state    <= ST_SORT;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        ST_SORT: begin
          for (int j = 0; j < N; j++) begin
            if (j == int'(idx_lo)) begin
              samples[j] <= cas_lo;
            end else if (j == int'(idx_hi)) begin
              samples[j] <= cas_hi;
            end
          end
          if (k == KW'(HALF - 1)) begin
            k <= '0;
            if (pass == PW'(N - 1)) begin
              pass      <= '0;
              median    <= mid_next;
              state     <= ST_DONE;
              out_valid <= 1'b1;
            end else begin
              pass <= pass + 1'b1;
            end
          end else begin
            k <= k + 1'b1;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_LOAD;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= ST_LOAD;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_median_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_median_seq_ctrl : table vectors + scoreboard for the sequential median
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_median_seq_ctrl;

  localparam int N        = 7;
  localparam int W        = 4;
  localparam int SORT_CYC = N * (N - 1) / 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] median;
  logic         busy;

  always #5 clk = ~clk;

  median_seq_ctrl #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .median    (median),
    .busy      (busy)
  );

  typedef logic [N-1:0][W-1:0] frame_t;
  typedef struct {
    frame_t s;
    int     med;
    bit     gaps;
  } vec_t;

  vec_t vecs [4];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   hs_count = 0;
  int   exp_q [$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic frame_t mk(input int a, b, c, d, e, f, g);
    frame_t r;
    r[0] = a[W-1:0]; r[1] = b[W-1:0]; r[2] = c[W-1:0]; r[3] = d[W-1:0];
    r[4] = e[W-1:0]; r[5] = f[W-1:0]; r[6] = g[W-1:0];
    return r;
  endfunction

  // Reference median: insertion sort, pick the middle
  function automatic int model_median(input frame_t s);
    int v [N];
    int t;
    for (int i = 0; i < N; i++) v[i] = int'(s[i]);
    for (int i = 1; i < N; i++) begin
      t = v[i];
      for (int j = i - 1; j >= 0; j--) begin
        if (v[j] > t) begin
          v[j+1] = v[j];
          v[j]   = t;
        end
      end
    end
    return v[(N-1)/2];
  endfunction

  task automatic load(input frame_t s, input int count, input bit gaps);
    for (int n = 0; n < count; n++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_data  = W'($urandom);
          @(posedge clk); #1;
        end
      end
      chk("in_ready_load", in_ready, 1);
      in_valid = 1'b1;
      in_data  = s[n];
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_median(input string tag, input int hold);
    int lat = 0;
    int e;
    out_ready = (hold == 0);
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, SORT_CYC);
    if (!out_valid) return;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_nonempty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_median"}, int'(median), e);
    end
    out_ready = 1'b1;
    hs_count++;
    @(posedge clk); #1;
    chk({tag, "_released"}, int'({out_valid, in_ready, busy}), 3'b010);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hs0;
    int lat;
    frame_t f;

    vecs[0] = '{s: mk(3, 1, 4, 1, 5, 9, 2),        med: 3,  gaps: 1'b0};
    vecs[1] = '{s: mk(7, 7, 7, 7, 7, 7, 7),        med: 7,  gaps: 1'b0};
    vecs[2] = '{s: mk(15, 14, 13, 12, 11, 10, 9), med: 12, gaps: 1'b0};
    vecs[3] = '{s: mk(0, 15, 8, 8, 1, 14, 8),      med: 8,  gaps: 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", int'({out_valid, in_ready, busy}), 3'b010);
    chk("reset_median", int'(median), 0);
    rst = 1'b0;

    // Table-driven frames
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(vecs[i].med);
      load(vecs[i].s, N, vecs[i].gaps);
      chk($sformatf("vec%0d_busy", i), int'({busy, in_ready}), 2'b10);
      wait_median($sformatf("vec%0d", i), 0);
    end

    // Consumer stalls: outputs held, input beats ignored
    exp_q.push_back(12);
    load(vecs[2].s, N, 1'b0);
    out_ready = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("stall_latency", lat, SORT_CYC);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = W'($urandom);
      chk("stall_hold", int'({out_valid, in_ready, busy, median}), int'({3'b101, 4'd12}));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("stall_median", int'(median), exp_q.pop_front());
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release", int'({out_valid, in_ready}), 2'b01);
    chk("median_kept", int'(median), 12);
    exp_q.push_back(3);
    load(vecs[0].s, N, 1'b0);
    wait_median("after_stall", 0);

    // Reset mid-sort
    load(vecs[1].s, N, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("midsort_busy", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midsort_rst_outputs", int'({out_valid, in_ready, busy}), 3'b010);
    chk("midsort_rst_median", int'(median), 0);

    // Reset after a partial frame
    load(mk(15, 15, 15, 15, 0, 0, 0), 4, 1'b0);
    chk("partial_state", int'({out_valid, in_ready, busy}), 3'b010);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("partial_rst_outputs", int'({out_valid, in_ready, busy, median}), int'({3'b010, 4'd0}));
    exp_q.push_back(4);
    load(mk(6, 2, 9, 0, 4, 4, 1), N, 1'b0);
    wait_median("post_reset", 0);

    // Random frames against the model
    hs0 = hs_count;
    for (int r = 0; r < 200; r++) begin
      for (int n = 0; n < N; n++) f[n] = W'($urandom);
      exp_q.push_back(model_median(f));
      load(f, N, 1'(($urandom_range(0, 1))));
      wait_median("rand", int'($urandom_range(0, 2)));
    end
    chk("rand_handshakes", hs_count - hs0, 200);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
